// File: rtl/ibex_pkg.sv
// Shared Ibex definitions used by the instr/data bus arbiter.
package ibex_pkg;

  typedef enum logic {ArbSrcInstr, ArbSrcData} ibex_arb_src_e;

  parameter int unsigned ArbMaxOutstandingDefault = 2;

endpackage

// File: rtl/ibex_arb_src_fifo.sv
// Counter-based FIFO of issuing sources; head names the port owed the next response.
module ibex_arb_src_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = ArbMaxOutstandingDefault
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  ibex_arb_src_e src_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output ibex_arb_src_e head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  ibex_arb_src_e   r_mem [Depth];
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [CntW-1:0] r_cnt;
  logic            w_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (r_cnt == CntW'(Depth));
  assign empty_o = (r_cnt == '0);
  assign head_o  = r_mem[r_rptr];
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wptr] <= src_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (push_i) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      if (push_i && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !push_i) r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/ibex_bus_arbiter.sv
// Round-robin merge of Ibex instr and data ports onto one host port,
// with lock across stalls and in-order response routing.
module ibex_bus_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned MaxOutstanding = ArbMaxOutstandingDefault
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic [6:0]  instr_rdata_intg_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [6:0]  data_wdata_intg_i,
  output logic [31:0] data_rdata_o,
  output logic [6:0]  data_rdata_intg_o,
  output logic        data_err_o,
  output logic        host_req_o,
  input  logic        host_gnt_i,
  input  logic        host_rvalid_i,
  output logic        host_we_o,
  output logic [3:0]  host_be_o,
  output logic [31:0] host_addr_o,
  output logic [31:0] host_wdata_o,
  output logic [6:0]  host_wdata_intg_o,
  input  logic [31:0] host_rdata_i,
  input  logic [6:0]  host_rdata_intg_i,
  input  logic        host_err_i,
  output logic        spurious_rvalid_o
);

  ibex_arb_src_e r_prio, r_lock_src, w_sel, w_head;
  logic          r_lock, w_sel_req, w_is_instr, w_hs, w_full, w_empty;

  // A locked source wins outright so host fields cannot change mid-stall.
  always_comb begin
    w_sel = r_prio;
    if (r_lock)                            w_sel = r_lock_src;
    else if (instr_req_i && !data_req_i)   w_sel = ArbSrcInstr;
    else if (data_req_i && !instr_req_i)   w_sel = ArbSrcData;
  end

  assign w_is_instr = (w_sel == ArbSrcInstr);
  assign w_sel_req  = w_is_instr ? instr_req_i : data_req_i;
  assign host_req_o = w_sel_req & ~w_full;
  assign w_hs       = host_req_o & host_gnt_i;

  assign host_addr_o       = w_is_instr ? instr_addr_i : data_addr_i;
  assign host_we_o         = w_is_instr ? 1'b0 : data_we_i;
  assign host_be_o         = w_is_instr ? 4'hF : data_be_i;
  assign host_wdata_o      = w_is_instr ? 32'h0 : data_wdata_i;
  assign host_wdata_intg_o = w_is_instr ? 7'h0 : data_wdata_intg_i;

  assign instr_gnt_o = w_hs & w_is_instr;
  assign data_gnt_o  = w_hs & ~w_is_instr;

  // Lock can never be set while full (no push happens while locked), so
  // a dropped locked request is the only way host_req_o falls while locked.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prio     <= ArbSrcInstr;
      r_lock     <= 1'b0;
      r_lock_src <= ArbSrcInstr;
    end else begin
      r_lock     <= host_req_o & ~host_gnt_i;
      r_lock_src <= w_sel;
      if (w_hs) r_prio <= w_is_instr ? ArbSrcData : ArbSrcInstr;
    end
  end

  ibex_arb_src_fifo #(.Depth(MaxOutstanding)) u_src_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_hs),
    .src_i   (w_sel),
    .pop_i   (host_rvalid_i),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head)
  );

  assign instr_rvalid_o    = host_rvalid_i & ~w_empty & (w_head == ArbSrcInstr);
  assign data_rvalid_o     = host_rvalid_i & ~w_empty & (w_head == ArbSrcData);
  assign spurious_rvalid_o = host_rvalid_i & w_empty;

  assign instr_rdata_o      = host_rdata_i;
  assign instr_rdata_intg_o = host_rdata_intg_i;
  assign instr_err_o        = host_err_i;
  assign data_rdata_o       = host_rdata_i;
  assign data_rdata_intg_o  = host_rdata_intg_i;
  assign data_err_o         = host_err_i;

endmodule

// File: tb/tb_ibex_bus_arbiter.sv
// Directed per-cycle vector bench for ibex_bus_arbiter with MaxOutstanding=2.
module tb_ibex_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic [6:0]  instr_rdata_intg_o;
  logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_err_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic [6:0]  data_wdata_intg_i, data_rdata_intg_o;
  logic        host_req_o, host_gnt_i, host_rvalid_i, host_we_o, host_err_i;
  logic [3:0]  host_be_o;
  logic [31:0] host_addr_o, host_wdata_o, host_rdata_i;
  logic [6:0]  host_wdata_intg_o, host_rdata_intg_i;
  logic        spurious_rvalid_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  ibex_bus_arbiter #(.MaxOutstanding(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o),
    .instr_rdata_intg_o(instr_rdata_intg_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_wdata_intg_i(data_wdata_intg_i),
    .data_rdata_o(data_rdata_o), .data_rdata_intg_o(data_rdata_intg_o), .data_err_o(data_err_o),
    .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_rvalid_i(host_rvalid_i),
    .host_we_o(host_we_o), .host_be_o(host_be_o), .host_addr_o(host_addr_o),
    .host_wdata_o(host_wdata_o), .host_wdata_intg_o(host_wdata_intg_o),
    .host_rdata_i(host_rdata_i), .host_rdata_intg_i(host_rdata_intg_i), .host_err_i(host_err_i),
    .spurious_rvalid_o(spurious_rvalid_o)
  );

  // exp_hs = {host_req, instr_gnt, data_gnt, instr_rvalid, data_rvalid, spurious}
  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        err;
    logic [5:0]  exp_hs;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ireq, logic [31:0] iaddr, logic dreq, logic dwe,
                              logic [3:0] dbe, logic [31:0] daddr, logic [31:0] dwdata,
                              logic gnt, logic rv, logic [31:0] rdata, logic err,
                              logic [5:0] exp_hs, logic [31:0] exp_addr, logic exp_we,
                              logic [3:0] exp_be, logic [31:0] exp_wdata);
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe; v.dbe = dbe;
    v.daddr = daddr; v.dwdata = dwdata; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.err = err; v.exp_hs = exp_hs; v.exp_addr = exp_addr; v.exp_we = exp_we;
    v.exp_be = exp_be; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] hs();
    return {host_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, spurious_rvalid_o};
  endfunction

  task automatic drive(input vec_t v);
    instr_req_i       = v.ireq;
    instr_addr_i      = v.iaddr;
    data_req_i        = v.dreq;
    data_we_i         = v.dwe;
    data_be_i         = v.dbe;
    data_addr_i       = v.daddr;
    data_wdata_i      = v.dwdata;
    data_wdata_intg_i = v.dwdata[6:0];
    host_gnt_i        = v.gnt;
    host_rvalid_i     = v.rv;
    host_rdata_i      = v.rdata;
    host_rdata_intg_i = v.rdata[6:0] ^ 7'h11;
    host_err_i        = v.err;
  endtask

  task automatic check_vec(input string nm, input vec_t v);
    chk({nm, " hs"}, 32'(hs()), 32'(v.exp_hs));
    if (v.exp_hs[5]) begin
      chk({nm, " addr"}, host_addr_o, v.exp_addr);
      chk({nm, " we_be"}, 32'({host_we_o, host_be_o}), 32'({v.exp_we, v.exp_be}));
      chk({nm, " wdata"}, host_wdata_o, v.exp_wdata);
      chk({nm, " wintg"}, 32'(host_wdata_intg_o), 32'(v.exp_wdata[6:0]));
    end
    if (v.rv) begin
      chk({nm, " i_rdata"}, instr_rdata_o, v.rdata);
      chk({nm, " d_rdata"}, data_rdata_o, v.rdata);
      chk({nm, " rintg"}, 32'({instr_rdata_intg_o, data_rdata_intg_o}),
          32'({v.rdata[6:0] ^ 7'h11, v.rdata[6:0] ^ 7'h11}));
      chk({nm, " err"}, 32'({instr_err_o, data_err_o}), 32'({v.err, v.err}));
    end
  endtask

  localparam logic [31:0] Z = 32'h0;

  initial begin
    vec_t idle;
    idle = mk(0, Z, 0, 0, 4'h0, Z, Z, 0, 0, Z, 0, 6'b000000, Z, 0, 4'h0, Z);

    // reset-state idle, then single instr read
    vecs.push_back(idle);
    vecs.push_back(mk(1, 32'h100, 0, 0, 4'h0, Z, Z, 1, 0, Z, 0, 6'b110000, 32'h100, 0, 4'hF, Z));
    vecs.push_back(mk(0, Z, 0, 0, 4'h0, Z, Z, 0, 1, 32'hDEADBEEF, 0, 6'b000100, Z, 0, 4'h0, Z));
    // data read answered with error, then a spurious rvalid
    vecs.push_back(mk(0, Z, 1, 0, 4'hF, 32'h300, Z, 1, 0, Z, 0, 6'b101000, 32'h300, 0, 4'hF, Z));
    vecs.push_back(mk(0, Z, 0, 0, 4'h0, Z, Z, 0, 1, 32'hBAD0BAD0, 1, 6'b000010, Z, 0, 4'h0, Z));
    vecs.push_back(mk(0, Z, 0, 0, 4'h0, Z, Z, 0, 1, 32'h0000AAAA, 0, 6'b000001, Z, 0, 4'h0, Z));
    // contention: alternate grants, each response one cycle behind
    vecs.push_back(mk(1, 32'h400, 1, 1, 4'hF, 32'h500, 32'h11223344, 1, 0, Z, 0, 6'b110000, 32'h400, 0, 4'hF, Z));
    vecs.push_back(mk(1, 32'h400, 1, 1, 4'hF, 32'h500, 32'h11223344, 1, 1, 32'hA1, 0, 6'b101100, 32'h500, 1, 4'hF, 32'h11223344));
    vecs.push_back(mk(1, 32'h404, 1, 1, 4'hF, 32'h504, 32'h55667788, 1, 1, 32'hA2, 0, 6'b110010, 32'h404, 0, 4'hF, Z));
    vecs.push_back(mk(1, 32'h408, 1, 1, 4'hF, 32'h504, 32'h55667788, 1, 1, 32'hA3, 0, 6'b101100, 32'h504, 1, 4'hF, 32'h55667788));
    vecs.push_back(mk(0, Z, 0, 0, 4'h0, Z, Z, 0, 1, 32'hA4, 0, 6'b000010, Z, 0, 4'h0, Z));
    // stall lock: data write held while instr waits
    vecs.push_back(mk(0, Z, 1, 1, 4'h3, 32'h200, 32'hCAFE, 0, 0, Z, 0, 6'b100000, 32'h200, 1, 4'h3, 32'hCAFE));
    vecs.push_back(mk(1, 32'h600, 1, 1, 4'h3, 32'h200, 32'hCAFE, 0, 0, Z, 0, 6'b100000, 32'h200, 1, 4'h3, 32'hCAFE));
    vecs.push_back(mk(1, 32'h600, 1, 1, 4'h3, 32'h200, 32'hCAFE, 0, 0, Z, 0, 6'b100000, 32'h200, 1, 4'h3, 32'hCAFE));
    vecs.push_back(mk(1, 32'h600, 1, 1, 4'h3, 32'h200, 32'hCAFE, 1, 0, Z, 0, 6'b101000, 32'h200, 1, 4'h3, 32'hCAFE));
    vecs.push_back(mk(1, 32'h600, 0, 1, 4'h3, Z, 32'hFFFFFFFF, 1, 0, Z, 0, 6'b110000, 32'h600, 0, 4'hF, Z));
    // full: two outstanding, issue blocked even in the pop cycle
    vecs.push_back(mk(1, 32'h700, 0, 0, 4'h0, Z, Z, 1, 0, Z, 0, 6'b000000, Z, 0, 4'h0, Z));
    vecs.push_back(mk(1, 32'h700, 0, 0, 4'h0, Z, Z, 1, 1, 32'hB1, 0, 6'b000010, Z, 0, 4'h0, Z));
    vecs.push_back(mk(1, 32'h700, 0, 0, 4'h0, Z, Z, 1, 0, Z, 0, 6'b110000, 32'h700, 0, 4'hF, Z));

    drive(idle);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk_i);
      drive(vecs[i]);
      #1;
      check_vec($sformatf("v%0d", i), vecs[i]);
    end

    // reset with two transactions outstanding
    @(negedge clk_i);
    drive(idle);
    rst_ni = 1'b0;
    #1;
    chk("rst hs", 32'(hs()), 32'h0);
    host_rdata_i = 32'h5A5A0001;
    #1;
    chk("rst rdata pass", instr_rdata_o, 32'h5A5A0001);
    @(negedge clk_i);
    rst_ni = 1'b1;
    host_rvalid_i = 1'b1;
    #1;
    chk("post-rst spurious", 32'(hs()), 32'b000001);
    @(negedge clk_i);
    drive(mk(1, 32'h800, 0, 0, 4'h0, Z, Z, 1, 0, Z, 0, 6'b110000, 32'h800, 0, 4'hF, Z));
    #1;
    chk("post-rst issue", 32'(hs()), 32'b110000);
    @(negedge clk_i);
    drive(idle);
    host_rvalid_i = 1'b1;
    #1;
    chk("post-rst route", 32'(hs()), 32'b000100);
    @(negedge clk_i);
    drive(idle);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ibex_bus_arbiter.md
# ibex_bus_arbiter

Merges the Ibex core's instruction-fetch and data-LSU request/grant/rvalid ports onto a single host memory port, for single-port SRAM systems built around `ibex_top`. It arbitrates round-robin between the two requesters and holds the selection stable across host stalls. It tracks up to `MaxOutstanding` in-flight transactions so each host response, including integrity bits and error, goes back to the port that issued it.

## Interface
- `MaxOutstanding`, default 2: depth of the source-tracking FIFO. Legal range 1..8.
- `clk_i`  in  1  core clock
- `rst_ni`  in  1  reset; one clock; asynchronous, active-low
- `instr_req_i` / `instr_gnt_o` / `instr_rvalid_o`  in/out/out  1 each  instruction port handshake
- `instr_addr_i`  in  32  fetch address
- `instr_rdata_o`  out  32  fetch data
- `instr_rdata_intg_o`  out  7  fetch data integrity
- `instr_err_o`  out  1  fetch bus error
- `data_req_i` / `data_gnt_o` / `data_rvalid_o`  in/out/out  1 each  data port handshake
- `data_we_i`  in  1  write enable
- `data_be_i`  in  4  byte enables
- `data_addr_i`  in  32  data address
- `data_wdata_i`  in  32  write data
- `data_wdata_intg_i`  in  7  write data integrity
- `data_rdata_o`  out  32  read data
- `data_rdata_intg_o`  out  7  read data integrity
- `data_err_o`  out  1  data bus error
- `host_req_o` / `host_gnt_i` / `host_rvalid_i`  out/in/in  1 each  host port handshake
- `host_we_o`, `host_be_o`, `host_addr_o`, `host_wdata_o`, `host_wdata_intg_o`  out  1/4/32/32/7  host request fields
- `host_rdata_i`, `host_rdata_intg_i`, `host_err_i`  in  32/7/1  host response
- `spurious_rvalid_o`  out  1  one-cycle pulse when `host_rvalid_i` arrives with no transaction outstanding

## Operation
**Arbitration state**
- `prio_q` names the preferred source. Reset value: instr.
- `lock_q`/`lock_src_q` record a presented-but-ungranted request. Reset value: unlocked.

**Request selection**
- Locked: the locked source is selected.
- Unlocked, one requester: that requester is selected.
- Unlocked, both requesting: the `prio_q` source is selected.

**Issue**
- `host_req_o` = selected req AND NOT `full`.
- Request fields are muxed from the selected source.
- When instr is selected: `host_we_o`=0, `host_be_o`=4'hF, `host_wdata_o`=0, `host_wdata_intg_o`=0.
- The selected port's gnt = `host_gnt_i` AND `host_req_o`. The other port's gnt = 0.

**Lock**
- Set when `host_req_o` is high and `host_gnt_i` is low.
- Cleared on the granting handshake.
- While locked, the other requester cannot be selected. This keeps host fields stable, as the protocol requires.

**Round-robin**
- On each handshake, `prio_q` moves to the source that was not granted.

**Source FIFO**
- `MaxOutstanding`-entry, 1-bit-wide.
- Push: source on handshake.
- Pop: on `host_rvalid_i` when not empty.
- `full` = count == `MaxOutstanding`. While full, issue is blocked even if a pop occurs in the same cycle, so no rvalid→req combinational path exists.
- Push and pop in the same cycle (not full) leave the count unchanged.

**Response routing**
- The FIFO head selects which rvalid to assert. The other rvalid stays 0.
- rdata, rdata_intg and err fan out to both ports unqualified.

**Spurious response**
- `host_rvalid_i` while the FIFO is empty: no rvalid to either port, `spurious_rvalid_o` = 1, FIFO unchanged.

**Requester rule**
- A requester holds req until gnt. A dropped ungranted req while locked clears the lock in the next cycle.

## Timing
- Request path: zero latency; req → `host_req_o` → gnt is combinational.
- Response path: zero latency; `host_rvalid_i` → port rvalid is combinational.
- Throughput: one handshake per cycle while not full.
- Reset values:
  - `host_req_o`, both gnt, both rvalid and `spurious_rvalid_o` are 0.
  - The FIFO is empty.
  - The response-data outputs pass through from the host inputs.
- Reset mid-operation: in-flight transactions are discarded. Any later rvalid reports as spurious.

## Structure
- Shared package `ibex_pkg` gains:
  - `typedef enum logic {ArbSrcInstr, ArbSrcData} ibex_arb_src_e`
  - `parameter int unsigned ArbMaxOutstandingDefault = 2`
- Sub-module `ibex_arb_src_fifo`: a counter-based, pointer-wrapping FIFO of `ibex_arb_src_e`. It outputs full, empty and head.
- Arbitration, lock and muxing live in the top module.

## Test plan
- **Single instr read:** addr 0x100 with `host_gnt_i`=1 → `instr_gnt_o`=1 in the same cycle. Host rvalid with rdata 0xDEADBEEF one cycle later → `instr_rvalid_o`=1 with that data; `data_rvalid_o`=0.
- **Contention:** both req high for 4 cycles, gnt always 1 → grant order instr, data, instr, data. Host responses route to the issuing source in order.
- **Stall lock:** data write at 0x200 with be 4'h3 presented and `host_gnt_i` low for 3 cycles; instr req asserted in cycle 1 → host fields hold the data write throughout. Instr is granted only after the data handshake.
- **Full:** `MaxOutstanding`=2, two handshakes with no rvalid → third req sees `host_req_o`=0. In the cycle rvalid arrives `host_req_o` is still 0; it rises the following cycle.
- **Spurious and error:** rvalid with an empty FIFO → `spurious_rvalid_o` pulse and no port rvalid. A data read answered with `host_err_i`=1 → `data_err_o`=1 with `data_rvalid_o`.
- **Reset mid-flight:** `rst_ni` low with 2 outstanding transactions → all outputs return to reset values; the next rvalid is spurious.
